uart_frame_ctrl: RTL and testbench

Framing controller between the UART byte engines (`uart_rx`, `uart_tx`) and the motor-control logic on the TinyFPGA BX board.
- Receive side: hunts for the 32-bit magic header in the incoming byte stream, collects a fixed-length payload and checks its CRC-16. It publishes the payload only when the CRC matches.
- Transmit side: on request, sequences `uart_tx` byte by byte through a response frame (magic, payload, CRC-16).
- RX and TX run independently (full duplex).

---
 rtl/uart_frame_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_ctrl.sv
// Byte-level framing between uart_rx/uart_tx and the motor controller:
// RX hunts MAGIC, collects a payload and checks CRC-16-CCITT; TX sequences a response frame.
module uart_frame_ctrl #(
    parameter int unsigned PAYLOAD_BYTES  = 4,
    parameter logic [31:0] MAGIC          = 32'hDABBAD00,
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter logic [15:0] CRC_INIT       = 16'hFFFF
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         rx_valid,
    input  logic [7:0]                   rx_byte,
    input  logic                         tx_active,
    input  logic                         tx_done,
    output logic                         tx_start,
    output logic [7:0]                   tx_byte,
    output logic [8*PAYLOAD_BYTES-1:0]   rx_payload,
    output logic                         rx_frame_ok,
    output logic                         rx_crc_err,
    output logic                         rx_timeout,
    input  logic                         tx_req,
    input  logic [8*PAYLOAD_BYTES-1:0]   tx_payload,
    output logic                         tx_busy,
    output logic                         tx_frame_done
);
    localparam int unsigned N    = PAYLOAD_BYTES + 6;
    localparam int unsigned IDXW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int unsigned KW   = $clog2(N);
    localparam int unsigned GW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0][7:0] MAGIC_B = MAGIC;

    // One byte of CRC-16-CCITT (poly 0x1021, MSB first), eight shift steps unrolled.
    function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    // ---------------- receive ----------------
    typedef enum logic [1:0] {R_HUNT, R_PAYLOAD, R_CRC_HI, R_CRC_LO} rx_state_t;
    rx_state_t rx_state, rx_state_nx;

    logic [31:0]                    rx_shift;
    logic [PAYLOAD_BYTES-1:0][7:0]  rx_buf;
    logic [IDXW-1:0]                rx_idx;
    logic [15:0]                    rx_crc, rx_crc_nx;
    logic [7:0]                     rx_crc_hi;
    logic [GW-1:0]                  rx_gap;
    logic rx_expire, rx_take, rx_magic_hit, rx_last_pl, rx_crc_match;

    // Expiry wins over a byte arriving in the same cycle.
    assign rx_expire    = (rx_state != R_HUNT) && (rx_gap == GW'(TIMEOUT_CYCLES - 1));
    assign rx_take      = rx_valid && !rx_expire;
    assign rx_magic_hit = ({rx_shift[23:0], rx_byte} == MAGIC);
    assign rx_last_pl   = (rx_idx == IDXW'(PAYLOAD_BYTES - 1));
    assign rx_crc_match = ({rx_crc_hi, rx_byte} == rx_crc);
    assign rx_crc_nx    = crc16_upd(rx_crc, rx_byte);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rx_state <= R_HUNT;
        else        rx_state <= rx_state_nx;
    end

    always_comb begin
        rx_state_nx = rx_state;
        if (rx_expire) rx_state_nx = R_HUNT;
        else if (rx_take) begin
            case (rx_state)
                R_HUNT:    if (rx_magic_hit) rx_state_nx = R_PAYLOAD;
                R_PAYLOAD: if (rx_last_pl) rx_state_nx = R_CRC_HI;
                R_CRC_HI:  rx_state_nx = R_CRC_LO;
                R_CRC_LO:  rx_state_nx = R_HUNT;
                default:   rx_state_nx = R_HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_shift    <= '0;
            rx_buf      <= '0;
            rx_idx      <= '0;
            rx_crc      <= '0;
            rx_crc_hi   <= '0;
            rx_gap      <= '0;
            rx_payload  <= '0;
            rx_frame_ok <= 1'b0;
            rx_crc_err  <= 1'b0;
            rx_timeout  <= 1'b0;
        end else begin
            rx_frame_ok <= 1'b0;
            rx_crc_err  <= 1'b0;
            rx_timeout  <= rx_expire;
            if (rx_state == R_HUNT || rx_valid || rx_expire) rx_gap <= '0;
            else                                             rx_gap <= rx_gap + GW'(1);
            if (rx_expire) rx_shift <= '0;
            else if (rx_take) begin
                case (rx_state)
                    R_HUNT: begin
                        if (rx_magic_hit) begin
                            rx_crc <= CRC_INIT;
                            rx_idx <= '0;
                        end else begin
                            rx_shift <= {rx_shift[23:0], rx_byte};
                        end
                    end
                    R_PAYLOAD: begin
                        rx_buf[rx_idx] <= rx_byte;
                        rx_crc         <= rx_crc_nx;
                        rx_idx         <= rx_idx + IDXW'(1);
                    end
                    R_CRC_HI: rx_crc_hi <= rx_byte;
                    R_CRC_LO: begin
                        if (rx_crc_match) begin
                            rx_payload  <= rx_buf;
                            rx_frame_ok <= 1'b1;
                        end else begin
                            rx_crc_err  <= 1'b1;
                        end
                        rx_shift <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- transmit ----------------
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} tx_state_t;
    tx_state_t tx_state, tx_state_nx;

    logic [KW-1:0]                  tx_k;
    logic [15:0]                    tx_crc, tx_crc_nx;
    logic [PAYLOAD_BYTES-1:0][7:0]  tx_pl;
    logic [7:0]                     tx_seq_byte;
    logic [IDXW-1:0]                tx_pidx;
    logic                           tx_is_pl, tx_last;

    assign tx_last   = (tx_k == KW'(N - 1));
    assign tx_crc_nx = crc16_upd(tx_crc, tx_seq_byte);

    // Byte k of the outgoing frame; CRC bytes read the crc after all payload updates.
    always_comb begin
        tx_pidx     = IDXW'(tx_k - KW'(4));
        tx_is_pl    = (tx_k >= KW'(4)) && (tx_k < KW'(4 + PAYLOAD_BYTES));
        tx_seq_byte = tx_crc[7:0];
        if (tx_k < KW'(4))               tx_seq_byte = MAGIC_B[2'd3 - tx_k[1:0]];
        else if (tx_is_pl)               tx_seq_byte = tx_pl[tx_pidx];
        else if (tx_k == KW'(N - 2))     tx_seq_byte = tx_crc[15:8];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) tx_state <= T_IDLE;
        else        tx_state <= tx_state_nx;
    end

    always_comb begin
        tx_state_nx = tx_state;
        case (tx_state)
            T_IDLE:  if (tx_req) tx_state_nx = T_SEND;
            T_SEND:  if (!tx_active) tx_state_nx = T_WAIT;
            T_WAIT:  if (tx_done) tx_state_nx = tx_last ? T_IDLE : T_SEND;
            default: tx_state_nx = T_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_k          <= '0;
            tx_crc        <= '0;
            tx_pl         <= '0;
            tx_byte       <= '0;
            tx_start      <= 1'b0;
            tx_busy       <= 1'b0;
            tx_frame_done <= 1'b0;
        end else begin
            tx_start      <= 1'b0;
            tx_frame_done <= 1'b0;
            case (tx_state)
                T_IDLE: begin
                    if (tx_req) begin
                        tx_pl   <= tx_payload;
                        tx_k    <= '0;
                        tx_crc  <= CRC_INIT;
                        tx_busy <= 1'b1;
                    end
                end
                T_SEND: begin
                    if (!tx_active) begin
                        tx_byte  <= tx_seq_byte;
                        tx_start <= 1'b1;
                        if (tx_is_pl) tx_crc <= tx_crc_nx;
                    end
                end
                T_WAIT: begin
                    if (tx_done) begin
                        if (tx_last) begin
                            tx_busy       <= 1'b0;
                            tx_frame_done <= 1'b1;
                        end else begin
                            tx_k <= tx_k + KW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: frame-level RX model checked every cycle, a uart_tx
// stand-in that records launched bytes, and directed scenarios with literal expectations.
module tb_uart_frame_ctrl;
    localparam int          P     = 9;
    localparam int          TMO   = 100;
    localparam logic [31:0] MAGIC = 32'hDABBAD00;
    localparam logic [8*P-1:0] PL1 = 72'h393837363534333231;   // "123456789"
    localparam logic [8*P-1:0] PL2 = 72'hA8A7A6A5A4A3A2A1A0;
    localparam logic [8*P-1:0] PL3 = 72'h090807060504030201;

    logic CLK = 1'b0;
    logic RST_N;
    logic rx_valid, tx_active, tx_done, tx_start, tx_req, tx_busy, tx_frame_done;
    logic rx_frame_ok, rx_crc_err, rx_timeout;
    logic [7:0] rx_byte, tx_byte;
    logic [8*P-1:0] rx_payload, tx_payload;

    uart_frame_ctrl #(.PAYLOAD_BYTES(P), .MAGIC(MAGIC), .TIMEOUT_CYCLES(TMO), .CRC_INIT(16'hFFFF)) dut (
        .CLK(CLK), .RST_N(RST_N), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_active(tx_active), .tx_done(tx_done), .tx_start(tx_start), .tx_byte(tx_byte),
        .rx_payload(rx_payload), .rx_frame_ok(rx_frame_ok), .rx_crc_err(rx_crc_err),
        .rx_timeout(rx_timeout), .tx_req(tx_req), .tx_payload(tx_payload),
        .tx_busy(tx_busy), .tx_frame_done(tx_frame_done)
    );

    always #5 CLK = ~CLK;

    int errs = 0, checks = 0;
    int n_ok = 0, n_err = 0, n_to = 0, n_fd = 0, n_start = 0;
    logic [7:0] txq[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Bit-serial reference CRC over a whole payload.
    function automatic logic [15:0] crc_ref(input logic [8*P-1:0] pl);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int i = 0; i < P; i++)
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ pl[8*i+b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        return c;
    endfunction

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // Frame-level RX model: sliding header search, byte collection, whole-frame CRC verdict.
    initial begin
        int cyc, last_cyc;
        bit in_frame;
        logic [31:0] win;
        logic [7:0] fq[$];
        logic e_ok, e_err, e_to;
        logic [8*P-1:0] e_pl, cand;
        cyc = 0; last_cyc = 0; in_frame = 0; win = '0;
        e_ok = 0; e_err = 0; e_to = 0; e_pl = '0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RST_N) begin
                in_frame = 0; win = '0; fq.delete();
                e_ok = 0; e_err = 0; e_to = 0; e_pl = '0;
            end else begin
                chk("rx_frame_ok", rx_frame_ok, e_ok);
                chk("rx_crc_err", rx_crc_err, e_err);
                chk("rx_timeout", rx_timeout, e_to);
                chk("rx_payload", rx_payload, e_pl);
                if (rx_frame_ok) n_ok++;
                if (rx_crc_err) n_err++;
                if (rx_timeout) n_to++;
                if (tx_frame_done) n_fd++;
                if (tx_start) chk("tx_start_while_active", tx_active, 1'b0);
                e_ok = 0; e_err = 0; e_to = 0;
                if (in_frame && (cyc - last_cyc == TMO)) begin
                    e_to = 1; in_frame = 0; win = '0;
                end else if (rx_valid) begin
                    if (!in_frame) begin
                        if ({win[23:0], rx_byte} == MAGIC) begin
                            in_frame = 1; fq.delete(); last_cyc = cyc;
                        end else begin
                            win = {win[23:0], rx_byte};
                        end
                    end else begin
                        fq.push_back(rx_byte);
                        last_cyc = cyc;
                        if (fq.size() == P + 2) begin
                            for (int i = 0; i < P; i++) cand[8*i +: 8] = fq[i];
                            if (crc_ref(cand) == {fq[P], fq[P+1]}) begin
                                e_ok = 1; e_pl = cand;
                            end else begin
                                e_err = 1;
                            end
                            in_frame = 0; win = '0;
                        end
                    end
                end
            end
        end
    end

    // uart_tx stand-in: busy for a few cycles after each start, then a one-cycle done.
    initial begin
        int cnt;
        logic s;
        logic [7:0] b;
        tx_active = 0; tx_done = 0; cnt = 0;
        forever begin
            @(negedge CLK);
            s = tx_start; b = tx_byte;
            @(posedge CLK); #1;
            tx_done = 0;
            if (!RST_N) begin
                tx_active = 0; cnt = 0;
            end else if (tx_active) begin
                if (cnt == 0) begin
                    chk("tx_byte_hold", tx_byte, txq[txq.size()-1]);
                    tx_active = 0; tx_done = 1;
                end else cnt--;
            end else if (s) begin
                txq.push_back(b); n_start++; tx_active = 1; cnt = 3;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1; rx_byte = b;
        tick();
        rx_valid = 0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic [8*P-1:0] pl, input logic [15:0] crc_x,
                              input int gap_idx, input int gap_len);
        logic [7:0] fb[$];
        logic [15:0] c;
        for (int i = 3; i >= 0; i--) fb.push_back(MAGIC[8*i +: 8]);
        for (int i = 0; i < P; i++) fb.push_back(pl[8*i +: 8]);
        c = crc_ref(pl) ^ crc_x;
        fb.push_back(c[15:8]);
        fb.push_back(c[7:0]);
        foreach (fb[i]) send_byte(fb[i], (i == gap_idx) ? gap_len : 1);
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rx_payload"}, rx_payload, '0);
        chk({tag, "_rx_frame_ok"}, rx_frame_ok, 1'b0);
        chk({tag, "_rx_crc_err"}, rx_crc_err, 1'b0);
        chk({tag, "_rx_timeout"}, rx_timeout, 1'b0);
        chk({tag, "_tx_start"}, tx_start, 1'b0);
        chk({tag, "_tx_byte"}, tx_byte, 8'h00);
        chk({tag, "_tx_busy"}, tx_busy, 1'b0);
        chk({tag, "_tx_frame_done"}, tx_frame_done, 1'b0);
    endtask

    task automatic tx_frame(input logic [8*P-1:0] pl, input bit extra_req);
        logic [7:0] exp[$];
        logic [15:0] c;
        int fd0;
        bit seen;
        txq.delete(); n_start = 0; fd0 = n_fd;
        tx_payload = pl; tx_req = 1;
        tick();
        tx_req = 0; tx_payload = ~pl;
        chk("tx_busy_after_req", tx_busy, 1'b1);
        chk("tx_start_edge0", tx_start, 1'b0);
        tick();
        chk("tx_start_edge1", tx_start, 1'b1);
        chk("tx_first_byte", tx_byte, MAGIC[31:24]);
        if (extra_req) begin
            repeat (20) tick();
            tx_req = 1;
            tick();
            tx_req = 0;
        end
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            tick();
            if (tx_frame_done) seen = 1;
        end
        chk("tx_frame_done_seen", seen, 1'b1);
        if (seen) chk("tx_busy_falls_with_done", tx_busy, 1'b0);
        for (int i = 3; i >= 0; i--) exp.push_back(MAGIC[8*i +: 8]);
        for (int i = 0; i < P; i++) exp.push_back(pl[8*i +: 8]);
        c = crc_ref(pl);
        exp.push_back(c[15:8]);
        exp.push_back(c[7:0]);
        chk("tx_byte_count", txq.size(), exp.size());
        foreach (exp[i]) if (i < txq.size()) chk($sformatf("tx_seq_byte%0d", i), txq[i], exp[i]);
        repeat (40) tick();
        chk("tx_no_second_frame", n_start, P + 6);
        chk("tx_frame_done_pulses", n_fd - fd0, 1);
        chk("tx_busy_idle", tx_busy, 1'b0);
    endtask

    initial begin
        int ok0;
        rx_valid = 0; rx_byte = '0; tx_req = 0; tx_payload = '0;
        RST_N = 0;
        repeat (3) tick();
        check_all_zero("reset");
        RST_N = 1;
        tick();

        chk("crc_ref_check_vector", crc_ref(PL1), 16'h29B1);

        // check vector frame
        send_frame(PL1, 16'h0000, -1, 0);
        chk("vec_ok_count", n_ok, 1);
        chk("vec_err_count", n_err, 0);
        chk("vec_payload", rx_payload, PL1);

        // corrupted CRC (29 B0), then a good frame
        send_frame(PL1, 16'h0001, -1, 0);
        chk("bad_err_count", n_err, 1);
        chk("bad_ok_count", n_ok, 1);
        chk("bad_payload_kept", rx_payload, PL1);
        send_frame(PL2, 16'h0000, -1, 0);
        chk("after_bad_ok_count", n_ok, 2);
        chk("after_bad_payload", rx_payload, PL2);

        // garbage 00 DA ahead of the header
        send_byte(8'h00, 1);
        send_byte(8'hDA, 1);
        send_frame(PL3, 16'h0000, -1, 0);
        chk("garbage_ok_count", n_ok, 3);
        chk("garbage_payload", rx_payload, PL3);

        // longest gap that still survives
        send_frame(PL1, 16'h0000, 5, TMO - 2);
        chk("gap_edge_ok_count", n_ok, 4);
        chk("gap_edge_no_timeout", n_to, 0);

        // stall after the second payload byte
        send_byte(8'hDA, 1); send_byte(8'hBB, 1); send_byte(8'hAD, 1); send_byte(8'h00, 1);
        send_byte(8'h31, 1); send_byte(8'h32, 1);
        repeat (150) tick();
        chk("timeout_count", n_to, 1);
        chk("timeout_no_ok", n_ok, 4);
        send_frame(PL2, 16'h0000, -1, 0);
        chk("post_timeout_ok_count", n_ok, 5);
        chk("post_timeout_payload", rx_payload, PL2);

        // TX sequence with an ignored mid-frame request
        tx_frame(PL1, 1'b1);
        if (txq.size() == P + 6) begin
            chk("tx_crc_hi_literal", txq[P+4], 8'h29);
            chk("tx_crc_lo_literal", txq[P+5], 8'hB1);
        end

        // reset with RX in PAYLOAD and TX in WAIT
        send_byte(8'hDA, 1); send_byte(8'hBB, 1); send_byte(8'hAD, 1); send_byte(8'h00, 1);
        send_byte(8'h31, 1); send_byte(8'h32, 1); send_byte(8'h33, 1);
        tx_payload = PL1; tx_req = 1;
        tick();
        tx_req = 0;
        repeat (4) tick();
        chk("pre_reset_tx_active", tx_active, 1'b1);
        chk("pre_reset_payload", rx_payload, PL2);
        RST_N = 0;
        #1;
        check_all_zero("mid_reset");
        repeat (3) tick();
        RST_N = 1;
        tick();

        // fresh frames in both directions at once
        ok0 = n_ok;
        fork
            send_frame(PL3, 16'h0000, -1, 0);
            tx_frame(PL2, 1'b0);
        join
        chk("post_reset_ok_count", n_ok, ok0 + 1);
        chk("post_reset_payload", rx_payload, PL3);
        chk("post_reset_err_count", n_err, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
